// File: rtl/oc_serial_tx_if.sv
// Byte handshake between an upstream source and oc_serial_tx.
// READY is combinational from the transmitter state.
interface oc_serial_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 READY;

    modport master (
        output DATA,
        output VALID,
        input  READY
    );

    modport slave (
        input  DATA,
        input  VALID,
        output READY
    );
endinterface

// File: rtl/oc_serial_tx.sv
// Serial framer feeding the open-collector encoder.
// DRIVE=1 requests the line pulled low; DRIVE=0 releases it.
module oc_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic          CLK,
    input  logic          RST,
    oc_serial_tx_if.slave bus,
    output logic          BUSY,
    output logic          DRIVE
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 drive_d, busy_d;
    logic                 accept, tick, last_stop;

    assign bus.READY = (state_q == S_IDLE);
    assign accept    = bus.VALID && bus.READY;
    assign tick      = (timer_q == T_LAST);
    // stop_q marks that the first of two stop periods is done
    assign last_stop = (STOP_BITS == 1) || stop_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_START;
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && idx_q == I_LAST)
                    state_d = PARITY_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick && last_stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (state_q != S_IDLE && !tick)
            timer_d = timer_q + 1'b1;

        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        if (accept) begin
            shift_d = bus.DATA;
            idx_d   = '0;
            par_d   = (^bus.DATA) ^ PARITY_ODD;
        end else if (state_q == S_DATA && tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
        end

        stop_d = (state_d == S_STOP) &&
                 (stop_q || (state_q == S_STOP && tick));
    end

    // Outputs follow the next state so they change on the same edge
    always_comb begin
        drive_d = 1'b0;
        unique case (state_d)
            S_START:  drive_d = 1'b1;
            S_DATA:   drive_d = ~shift_d[0];
            S_PARITY: drive_d = ~par_q;
            default:  drive_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            DRIVE   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            DRIVE   <= drive_d;
            BUSY    <= busy_d;
        end
    end
endmodule

// File: tb/tb_oc_serial_tx.sv
// Bench for oc_serial_tx: three parity/stop configurations in lockstep,
// each compared every cycle against a frame-waveform reference model.
module tb_oc_serial_tx;
    localparam int CPB = 4;

    logic       clk_tb = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [2:0] busy;
    logic [2:0] drive;
    logic [2:0] ready;

    always #5 clk_tb = ~clk_tb;

    oc_serial_tx_if #(.DATA_BITS(8)) bus0 ();
    oc_serial_tx_if #(.DATA_BITS(8)) bus1 ();
    oc_serial_tx_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.DATA  = data;
    assign bus0.VALID = valid;
    assign bus1.DATA  = data;
    assign bus1.VALID = valid;
    assign bus2.DATA  = data;
    assign bus2.VALID = valid;
    assign ready = {bus2.READY, bus1.READY, bus0.READY};

    oc_serial_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b0),
        .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) dut0 (
        .CLK(clk_tb), .RST(rst), .bus(bus0.slave),
        .BUSY(busy[0]), .DRIVE(drive[0])
    );

    oc_serial_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) dut1 (
        .CLK(clk_tb), .RST(rst), .bus(bus1.slave),
        .BUSY(busy[1]), .DRIVE(drive[1])
    );

    oc_serial_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b1),
        .PARITY_ODD(1'b1), .STOP_BITS(2)
    ) dut2 (
        .CLK(clk_tb), .RST(rst), .bus(bus2.slave),
        .BUSY(busy[2]), .DRIVE(drive[2])
    );

    int checks = 0;
    int errors = 0;

    int pen   [3] = '{0, 1, 1};
    bit podd  [3] = '{1'b0, 1'b0, 1'b1};
    int nstop [3] = '{1, 1, 2};

    bit wave [3][64];
    int pos  [3] = '{-1, -1, -1};
    int flen [3] = '{0, 0, 0};
    int bcnt [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected DRIVE for every cycle of a frame, bit by bit
    task automatic load_frame(input int d, input logic [7:0] b);
        int k;
        flen[d] = (1 + 8 + pen[d] + nstop[d]) * CPB;
        for (int c = 0; c < flen[d]; c++) begin
            k = c / CPB;
            if (k == 0)
                wave[d][c] = 1'b1;
            else if (k <= 8)
                wave[d][c] = ~b[k-1];
            else if (pen[d] != 0 && k == 9)
                wave[d][c] = ~((^b) ^ podd[d]);
            else
                wave[d][c] = 1'b0;
        end
        pos[d] = 0;
    endtask

    task automatic model_edge(input bit r, input bit v,
                              input logic [7:0] b);
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                pos[d] = -1;
            end else if (pos[d] >= 0) begin
                pos[d]++;
                if (pos[d] == flen[d]) pos[d] = -1;
            end else if (v) begin
                load_frame(d, b);
            end
        end
    endtask

    task automatic compare();
        logic ed;
        for (int d = 0; d < 3; d++) begin
            ed = (pos[d] >= 0) ? wave[d][pos[d]] : 1'b0;
            check($sformatf("drive%0d", d), 32'(drive[d]), 32'(ed));
            check($sformatf("busy%0d", d), 32'(busy[d]),
                  32'(pos[d] >= 0));
            check($sformatf("ready%0d", d), 32'(ready[d]),
                  32'(pos[d] < 0));
            if (busy[d] === 1'b1) bcnt[d]++;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] b);
        rst   = r;
        valid = v;
        data  = b;
        @(posedge clk_tb);
        model_edge(r, v, b);
        @(negedge clk_tb);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;

        repeat (3) step(1'b1, 1'b1, 8'hFF);
        idle(2);

        bcnt = '{0, 0, 0};
        step(1'b0, 1'b1, 8'hA5);
        idle(60);
        check("len_np", 32'(bcnt[0]), 32'd40);
        check("len_pe", 32'(bcnt[1]), 32'd44);
        check("len_po2", 32'(bcnt[2]), 32'd48);

        step(1'b0, 1'b1, 8'h00);
        repeat (41) step(1'b0, 1'b1, 8'hFF);
        idle(60);

        step(1'b0, 1'b1, 8'hA5);
        repeat (9) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        idle(60);

        step(1'b0, 1'b1, 8'hA5);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        idle(60);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 8'($urandom));
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
